// File: rtl/moving_sum.sv
// Boxcar running sum of the last DELAY accepted samples, with a shifted average and a window-full flag.
// Samples from the upstream delay line (ddata) are ignored until the window has filled.
module moving_sum #(
  parameter int N     = 5,
  parameter int DELAY = 4,
  parameter int SHIFT = 2,
  localparam int SW   = N + $clog2(DELAY + 1),
  localparam int CW   = $clog2(DELAY + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic                clr,
  input  logic [N-1:0]        idata,
  input  logic [N-1:0]        ddata,
  output logic [SW-1:0]       sum,
  output logic [SW-SHIFT-1:0] avg,
  output logic                valid
);

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CW-1:0] FULL_CNT = CW'(DELAY);

  state_t        state_q;
  logic [CW-1:0] fill_cnt_q;
  logic [CW-1:0] fill_cnt_d;
  logic [SW-1:0] sum_q;
  logic [SW-1:0] sum_d;
  logic [SW:0]   acc_ext;
  logic [SW:0]   sub_ext;
  logic          valid_q;

  // Stale delay-line contents must never be subtracted while the window fills.
  always_comb begin
    sub_ext    = (state_q == RUN) ? (SW+1)'(ddata) : '0;
    acc_ext    = {1'b0, sum_q} + (SW+1)'(idata) - sub_ext;
    sum_d      = acc_ext[SW-1:0];
    fill_cnt_d = fill_cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      sum_q      <= '0;
      valid_q    <= 1'b0;
    end else if (ce) begin
      sum_q <= sum_d;
      case (state_q)
        FILL: begin
          fill_cnt_q <= fill_cnt_d;
          if (fill_cnt_d == FULL_CNT) begin
            state_q <= RUN;
            valid_q <= 1'b1;
          end
        end
        RUN: begin
          fill_cnt_q <= FULL_CNT;
          valid_q    <= 1'b1;
        end
        default: begin
          state_q    <= FILL;
          fill_cnt_q <= '0;
          valid_q    <= 1'b0;
        end
      endcase
    end
  end

  assign sum   = sum_q;
  assign avg   = sum_q[SW-1:SHIFT];
  assign valid = valid_q;

endmodule

// File: tb/tb_moving_sum.sv
// Directed bench for moving_sum; ddata comes from a history of accepted samples acting as the delay line.
module tb_moving_sum;
  localparam int N     = 5;
  localparam int DELAY = 4;
  localparam int SHIFT = 2;
  localparam int SW    = 8;

  logic                clk = 1'b0;
  logic                rst_n, ce, clr;
  logic [N-1:0]        idata, ddata;
  logic [SW-1:0]       sum;
  logic [SW-SHIFT-1:0] avg;
  logic                valid;

  int checks = 0;
  int errors = 0;
  int hist[$];

  always #5 clk = ~clk;

  moving_sum #(.N(N), .DELAY(DELAY), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr),
    .idata(idata), .ddata(ddata),
    .sum(sum), .avg(avg), .valid(valid)
  );

  // One clock edge; ddata is the sample DELAY accepts back, or 31 while history is short.
  task automatic step(input logic c, input logic [N-1:0] d, input logic r = 1'b1, input logic cl = 1'b0);
    @(negedge clk);
    rst_n = r; clr = cl; ce = c; idata = d;
    if (hist.size() >= DELAY) ddata = N'(hist[hist.size()-DELAY]);
    else ddata = 5'd31;
    @(posedge clk);
    #1;
    if (!r || cl) hist.delete();
    else if (c) hist.push_back(int'(d));
  endtask

  task automatic test_reset();
    step(1'b1, 5'd7, 1'b0);
    checks++;
    if (sum !== 8'd0 || valid !== 1'b0 || avg !== 6'd0) begin
      errors++;
      $display("FAIL reset: sum=%0d valid=%0b avg=%0d required sum=0 valid=0 avg=0", sum, valid, avg);
    end
  endtask

  task automatic test_constant();
    logic [SW-1:0] es[6] = '{8'd4, 8'd8, 8'd12, 8'd16, 8'd16, 8'd16};
    logic          ev[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    step(1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 5'd4);
      checks++;
      if (sum !== es[i] || valid !== ev[i]) begin
        errors++;
        $display("FAIL constant[%0d]: sum=%0d valid=%0b required sum=%0d valid=%0b", i, sum, valid, es[i], ev[i]);
      end
    end
    checks++;
    if (avg !== 6'd4) begin
      errors++;
      $display("FAIL constant_avg: avg=%0d required 4", avg);
    end
  endtask

  task automatic test_ramp();
    logic [SW-1:0] es[8] = '{8'd1, 8'd3, 8'd6, 8'd10, 8'd14, 8'd18, 8'd22, 8'd26};
    step(1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, N'(i + 1));
      checks++;
      if (sum !== es[i]) begin
        errors++;
        $display("FAIL ramp[%0d]: sum=%0d required %0d", i, sum, es[i]);
      end
    end
    checks++;
    if (avg !== 6'd6 || valid !== 1'b1) begin
      errors++;
      $display("FAIL ramp_avg: avg=%0d valid=%0b required avg=6 valid=1", avg, valid);
    end
  endtask

  task automatic test_stall();
    logic [SW-1:0] es[8] = '{8'd4, 8'd4, 8'd8, 8'd8, 8'd12, 8'd12, 8'd16, 8'd16};
    logic          ev[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    step(1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      // Idle edges carry junk idata that must not be accepted.
      if (i % 2 == 0) step(1'b1, 5'd4);
      else step(1'b0, 5'd31);
      checks++;
      if (sum !== es[i] || valid !== ev[i]) begin
        errors++;
        $display("FAIL stall[%0d]: sum=%0d valid=%0b required sum=%0d valid=%0b", i, sum, valid, es[i], ev[i]);
      end
    end
  endtask

  task automatic test_garbage_fill();
    logic [SW-1:0] es[6] = '{8'd4, 8'd8, 8'd12, 8'd16, 8'd20, 8'd24};
    logic [N-1:0]  din[6] = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd8, 5'd8};
    step(1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, din[i]);
      checks++;
      if (sum !== es[i]) begin
        errors++;
        $display("FAIL garbage_fill[%0d]: sum=%0d ddata=%0d required sum=%0d", i, sum, ddata, es[i]);
      end
    end
  endtask

  task automatic test_clr_and_reset();
    logic [SW-1:0] es[4] = '{8'd4, 8'd8, 8'd12, 8'd16};
    step(1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 5'd4);
    step(1'b1, 5'd4, 1'b1, 1'b1);
    checks++;
    if (sum !== 8'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL clr: sum=%0d valid=%0b required sum=0 valid=0", sum, valid);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd4);
      checks++;
      if (sum !== es[i] || valid !== (i == 3)) begin
        errors++;
        $display("FAIL refill[%0d]: sum=%0d valid=%0b required sum=%0d valid=%0b", i, sum, valid, es[i], (i == 3));
      end
    end
    step(1'b1, 5'd4, 1'b1, 1'b1);
    step(1'b1, 5'd4);
    step(1'b1, 5'd4);
    step(1'b1, 5'd4, 1'b0);
    checks++;
    if (sum !== 8'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_midfill: sum=%0d valid=%0b required sum=0 valid=0", sum, valid);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 5'd4);
    checks++;
    if (sum !== 8'd12 || valid !== 1'b0) begin
      errors++;
      $display("FAIL refill_after_reset: sum=%0d valid=%0b required sum=12 valid=0", sum, valid);
    end
  endtask

  task automatic test_max();
    logic [SW-1:0] es[6] = '{8'd31, 8'd62, 8'd93, 8'd124, 8'd124, 8'd124};
    step(1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 5'd31);
      checks++;
      if (sum !== es[i]) begin
        errors++;
        $display("FAIL max[%0d]: sum=%0d required %0d", i, sum, es[i]);
      end
    end
    checks++;
    if (avg !== 6'd31 || valid !== 1'b1) begin
      errors++;
      $display("FAIL max_avg: avg=%0d valid=%0b required avg=31 valid=1", avg, valid);
    end
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; clr = 1'b0; idata = '0; ddata = '0;
    test_reset();
    test_constant();
    test_ramp();
    test_stall();
    test_garbage_fill();
    test_clr_and_reset();
    test_max();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
